// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: per-key FSM states,
// synchronizer depth and number of keys.
package key_pkg;

  localparam int SYNC_DEPTH = 2;
  localparam int NUM_KEYS   = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_st_e;

endpackage

// File: rtl/key_filter.sv
// One key: 2-flop synchronizer, 4-state debounce FSM and saturating counter.
// Release pulse logic exists only when KEY_RELEASE_FLAG_EN is defined.
module key_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic flag,
  output logic state
`ifdef KEY_RELEASE_FLAG_EN
  ,
  output logic rel
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  // The entry sample into a filter state is the first of DEBOUNCE_CNT,
  // so the counter only has to reach DEBOUNCE_CNT-2 and can never wrap.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 2);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  key_s;
  key_st_e               st_q, st_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  flag_q, flag_d;
`ifdef KEY_RELEASE_FLAG_EN
  logic                  rel_q, rel_d;
`endif

  assign key_s = sync_q[SYNC_DEPTH-1];

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    flag_d = 1'b0;
`ifdef KEY_RELEASE_FLAG_EN
    rel_d  = 1'b0;
`endif
    case (st_q)
      IDLE: begin
        if (!key_s) begin
          st_d  = PRESS_FILT;
          cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d   = DOWN;
          cnt_d  = '0;
          flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          st_d  = REL_FILT;
          cnt_d = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          st_d  = DOWN;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d  = IDLE;
          cnt_d = '0;
`ifdef KEY_RELEASE_FLAG_EN
          rel_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      st_q   <= IDLE;
      cnt_q  <= '0;
      flag_q <= 1'b0;
`ifdef KEY_RELEASE_FLAG_EN
      rel_q  <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], key_n};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
`ifdef KEY_RELEASE_FLAG_EN
      rel_q  <= rel_d;
`endif
    end
  end

  assign flag  = flag_q;
  assign state = (st_q == DOWN) || (st_q == REL_FILT);
`ifdef KEY_RELEASE_FLAG_EN
  assign rel   = rel_q;
`endif

endmodule

// File: rtl/key_04.sv
// Four-key debouncer: one key_filter per active-low button.
// Optional key_release pulse output enabled by KEY_RELEASE_FLAG_EN.
module key_04
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key0,
  input  logic                key1,
  input  logic                key2,
  input  logic                key3,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_state
`ifdef KEY_RELEASE_FLAG_EN
  ,
  output logic [NUM_KEYS-1:0] key_release
`endif
);

  logic [NUM_KEYS-1:0] key_n;

  assign key_n = {key3, key2, key1, key0};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_filter #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .key_n(key_n[g]),
      .flag (key_flag[g]),
      .state(key_state[g])
`ifdef KEY_RELEASE_FLAG_EN
      ,
      .rel  (key_release[g])
`endif
    );
  end

endmodule

// File: tb/tb_key_04.sv
// Scoreboard bench for key_04 with DEBOUNCE_CNT=10: stimulus queues the
// predicted output events, a negedge monitor matches what the DUT emits.
module tb_key_04;

  localparam int DB = 10;
  localparam int LAT = DB + 2;
`ifdef KEY_RELEASE_FLAG_EN
  localparam logic [3:0] REL_MASK = 4'hF;
`else
  localparam logic [3:0] REL_MASK = 4'h0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] flag;
    logic [3:0] state;
    logic [3:0] rel;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key0 = 1'b1, key1 = 1'b1, key2 = 1'b1, key3 = 1'b1;
  logic [3:0] key_flag, key_state, key_release;

  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  bit   chk_rst = 1'b0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  logic [3:0] prev_state = 4'b0;
  ev_t  q[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_04 #(.DEBOUNCE_CNT(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key0     (key0),
    .key1     (key1),
    .key2     (key2),
    .key3     (key3),
    .key_flag (key_flag),
    .key_state(key_state)
`ifdef KEY_RELEASE_FLAG_EN
    ,
    .key_release(key_release)
`endif
  );

`ifndef KEY_RELEASE_FLAG_EN
  assign key_release = 4'b0;
`endif

  task automatic push_ev(input int c, input logic [3:0] f, input logic [3:0] s,
                         input logic [3:0] r);
    ev_t e;
    e.cyc = c; e.flag = f; e.state = s; e.rel = r & REL_MASK;
    q.push_back(e);
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor / scoreboard: the only process that counts comparisons.
  always @(negedge clk) begin
    ev_t e;
    if (chk_rst) begin
      checks++;
      if ({key_flag, key_state, key_release} !== 12'b0) begin
        errs++;
        $display("FAIL reset_zero cyc=%0d flag=%b state=%b rel=%b want all 0",
                 cyc, key_flag, key_state, key_release);
      end
    end else if (mon_en) begin
      if (key_flag !== 4'b0 || key_release !== 4'b0 || key_state !== prev_state) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_event cyc=%0d flag=%b state=%b rel=%b",
                   cyc, key_flag, key_state, key_release);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.flag !== key_flag || e.state !== key_state ||
              e.rel !== key_release) begin
            errs++;
            $display("FAIL event got cyc=%0d flag=%b state=%b rel=%b want cyc=%0d flag=%b state=%b rel=%b",
                     cyc, key_flag, key_state, key_release, e.cyc, e.flag, e.state, e.rel);
          end
        end
      end
    end
    prev_state = key_state;
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errs++;
        $display("FAIL missing_events got pending=%0d want 0 (next cyc=%0d)",
                 q.size(), q[0].cyc);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end

  initial begin
    int c;
    // Reset with all keys released, then idle with no activity.
    chk_rst = 1'b1;
    wt(10);
    rst_n = 1'b1; chk_rst = 1'b0; mon_en = 1'b1;
    wt(20);

    // Clean press held 50 cycles.
    key0 = 1'b0; push_ev(cyc + LAT, 4'b0001, 4'b0001, 4'b0000);
    wt(50);
    key0 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0001);
    wt(25);

    // One sample short of qualifying: nothing happens.
    key0 = 1'b0; wt(DB - 1);
    key0 = 1'b1; wt(25);

    // Exactly DEBOUNCE_CNT low samples: qualifies.
    key0 = 1'b0; c = cyc; push_ev(c + LAT, 4'b0001, 4'b0001, 4'b0000);
    wt(DB);
    key0 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0001);
    wt(25);

    // Bouncing key1, then a clean hold.
    repeat (5) begin
      key1 = 1'b0; wt(3);
      key1 = 1'b1; wt(3);
    end
    key1 = 1'b0; push_ev(cyc + LAT, 4'b0010, 4'b0010, 4'b0000);
    wt(30);
    key1 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0010);
    wt(25);

    // Simultaneous key2/key3.
    key2 = 1'b0; key3 = 1'b0; push_ev(cyc + LAT, 4'b1100, 4'b1100, 4'b0000);
    wt(40);
    key2 = 1'b1; key3 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b1100);
    wt(25);

    // Staggered key2/key3 stay independent.
    key2 = 1'b0; push_ev(cyc + LAT, 4'b0100, 4'b0100, 4'b0000);
    wt(4);
    key3 = 1'b0; push_ev(cyc + LAT, 4'b1000, 4'b1100, 4'b0000);
    wt(30);
    key2 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b1000, 4'b0100);
    wt(4);
    key3 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b1000);
    wt(25);

    // Reset mid-press: re-qualified from scratch after release.
    key0 = 1'b0; wt(6);
    rst_n = 1'b0; chk_rst = 1'b1;
    wt(5);
    rst_n = 1'b1; chk_rst = 1'b0; push_ev(cyc + LAT, 4'b0001, 4'b0001, 4'b0000);
    wt(30);
    key0 = 1'b1; push_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b0001);
    wt(25);

    done = 1'b1;
  end

  initial begin
    #200us;
    $display("FAIL watchdog got timeout want summary");
    $fatal(1, "watchdog");
  end

endmodule
